cmd_seq_fsm: RTL and testbench

//  Parametrised, command-driven state sequencer with registered state output. Replaces fixed 4-state

---
 rtl/cmd_seq_fsm.sv | 146 ++++++++++++++
 tb/tb_cmd_seq_fsm.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_seq_fsm.sv
// Command-driven state sequencer: wrap-around stepping, direct jump, idle timeout to home,
// out-of-range state recovery and illegal-command lockout with sticky status.
module cmd_seq_fsm #(
  parameter int NUM_STATES = 6,
  parameter int STATE_W    = 3,
  parameter int MAX_ERR    = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd,
  input  logic [STATE_W-1:0] cmd_arg,
  output logic               cmd_ready,
  input  logic               err_clr,
  output logic [STATE_W-1:0] state_out,
  output logic               busy,
  output logic               err_sticky,
  output logic               locked,
  output logic               fault
);

  localparam int ERR_W = $clog2(MAX_ERR + 1);
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [STATE_W:0]   NUM_S    = (STATE_W + 1)'(NUM_STATES);
  localparam logic [STATE_W-1:0] LAST_S   = STATE_W'(NUM_STATES - 1);
  localparam logic [STATE_W-1:0] ZERO_S   = STATE_W'(32'd0);
  localparam logic [STATE_W-1:0] ONE_S    = STATE_W'(32'd1);
  localparam logic [ERR_W-1:0]   ERR_MAX  = ERR_W'(MAX_ERR);
  localparam logic [ERR_W-1:0]   ERR_ZERO = ERR_W'(32'd0);
  localparam logic [ERR_W-1:0]   ERR_ONE  = ERR_W'(32'd1);
  localparam logic [TMR_W-1:0]   TMR_ZERO = TMR_W'(32'd0);
  localparam logic [TMR_W-1:0]   TMR_ONE  = TMR_W'(32'd1);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADV  = 3'b001,
    OP_RET  = 3'b010,
    OP_HOME = 3'b011,
    OP_JUMP = 3'b100
  } op_e;

  logic [STATE_W-1:0] state_r, state_nxt_s;
  logic [ERR_W-1:0]   err_cnt_r, err_cnt_nxt_s, err_inc_s;
  logic [TMR_W-1:0]   timer_r, timer_nxt_s;
  logic               sticky_r, sticky_nxt_s;
  logic               locked_r, locked_nxt_s;
  logic               fault_r, fault_nxt_s;
  logic               illegal_s;
  logic               oor_s;

  assign state_out  = state_r;
  assign busy       = (state_r != ZERO_S);
  assign err_sticky = sticky_r;
  assign locked     = locked_r;
  assign fault      = fault_r;
  assign cmd_ready  = !locked_r;

  // State, error and timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ZERO_S;
      err_cnt_r <= ERR_ZERO;
      timer_r   <= TMR_ZERO;
      sticky_r  <= 1'b0;
      locked_r  <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      err_cnt_r <= err_cnt_nxt_s;
      timer_r   <= timer_nxt_s;
      sticky_r  <= sticky_nxt_s;
      locked_r  <= locked_nxt_s;
      fault_r   <= fault_nxt_s;
    end
  end

  // Next-state decode: recovery > lockout > accepted command > timeout > hold
  always_comb begin
    state_nxt_s   = state_r;
    timer_nxt_s   = timer_r;
    err_cnt_nxt_s = err_clr ? ERR_ZERO : err_cnt_r;
    sticky_nxt_s  = err_clr ? 1'b0 : sticky_r;
    locked_nxt_s  = locked_r;
    fault_nxt_s   = fault_r;
    illegal_s     = 1'b0;
    oor_s         = ({1'b0, state_r} >= NUM_S);
    err_inc_s     = (err_cnt_r == ERR_MAX) ? err_cnt_r : err_cnt_r + ERR_ONE;

    if (oor_s) begin
      state_nxt_s = ZERO_S;
      timer_nxt_s = TMR_ZERO;
      fault_nxt_s = 1'b1;
    end else if (locked_r) begin
      state_nxt_s = ZERO_S;
      timer_nxt_s = TMR_ZERO;
    end else if (cmd_valid) begin
      timer_nxt_s = TMR_ZERO;
      case (cmd)
        OP_NOP:  state_nxt_s = state_r;
        OP_ADV:  state_nxt_s = (state_r == LAST_S) ? ZERO_S : state_r + ONE_S;
        OP_RET:  state_nxt_s = (state_r == ZERO_S) ? LAST_S : state_r - ONE_S;
        OP_HOME: state_nxt_s = ZERO_S;
        OP_JUMP: begin
          if ({1'b0, cmd_arg} < NUM_S) begin
            state_nxt_s = cmd_arg;
          end else begin
            illegal_s = 1'b1;
          end
        end
        default: illegal_s = 1'b1;
      endcase
      // A clear arriving with an illegal command restarts the count at one, never locking
      if (illegal_s) begin
        sticky_nxt_s = 1'b1;
        if (err_clr) begin
          err_cnt_nxt_s = ERR_ONE;
        end else begin
          err_cnt_nxt_s = err_inc_s;
          if (err_inc_s == ERR_MAX) begin
            locked_nxt_s = 1'b1;
            state_nxt_s  = ZERO_S;
          end else begin
            locked_nxt_s = locked_r;
          end
        end
      end else begin
        sticky_nxt_s = sticky_nxt_s;
      end
    end else if (state_r == ZERO_S) begin
      timer_nxt_s = TMR_ZERO;
    end else if (TIMEOUT != 0) begin
      if (timer_r == TMR_LAST) begin
        state_nxt_s = ZERO_S;
        timer_nxt_s = TMR_ZERO;
      end else begin
        timer_nxt_s = timer_r + TMR_ONE;
      end
    end else begin
      timer_nxt_s = TMR_ZERO;
    end
  end

endmodule

// File: tb/tb_cmd_seq_fsm.sv
// Self-checking bench for cmd_seq_fsm: directed scenarios plus randomized traffic
// compared against a behavioural model of the command rules.
module tb_cmd_seq_fsm;

  localparam int N  = 6;
  localparam int SW = 3;
  localparam int ME = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic [SW-1:0] cmd_arg;
  logic          err_clr;
  logic          cmd_ready, busy, err_sticky, locked, fault;
  logic [SW-1:0] state_out;
  logic          z_ready, z_busy, z_sticky, z_locked, z_fault;
  logic [SW-1:0] z_state;

  int checks = 0;
  int errors = 0;

  int m_state, m_err, m_idle;
  bit m_sticky, m_locked, m_fault;

  always #5 clk = ~clk;

  cmd_seq_fsm #(.NUM_STATES(N), .STATE_W(SW), .MAX_ERR(ME), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_arg(cmd_arg),
    .cmd_ready(cmd_ready), .err_clr(err_clr), .state_out(state_out), .busy(busy),
    .err_sticky(err_sticky), .locked(locked), .fault(fault)
  );

  // Same stimulus, timer disabled
  cmd_seq_fsm #(.NUM_STATES(N), .STATE_W(SW), .MAX_ERR(ME), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_arg(cmd_arg),
    .cmd_ready(z_ready), .err_clr(err_clr), .state_out(z_state), .busy(z_busy),
    .err_sticky(z_sticky), .locked(z_locked), .fault(z_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state"},  32'(state_out),     32'(m_state));
    chk({tag, ".busy"},   32'(busy),          32'(m_state != 0));
    chk({tag, ".sticky"}, 32'(err_sticky),    32'(m_sticky));
    chk({tag, ".locked"}, 32'(locked),        32'(m_locked));
    chk({tag, ".fault"},  32'(fault),         32'(m_fault));
    chk({tag, ".ready"},  32'(cmd_ready),     32'(!m_locked));
    chk({tag, ".errcnt"}, 32'(dut.err_cnt_r), 32'(m_err));
  endtask

  task automatic model_reset();
    m_state = 0; m_err = 0; m_idle = 0;
    m_sticky = 1'b0; m_locked = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_clear();
    if (err_clr) begin
      m_err = 0;
      m_sticky = 1'b0;
    end
  endtask

  // One rising edge of the reference behaviour, using the inputs currently applied
  task automatic model_edge();
    bit bad;
    bad = 1'b0;
    if (m_state >= N) begin
      m_state = 0; m_fault = 1'b1; m_idle = 0;
      model_clear();
    end else if (m_locked) begin
      m_state = 0; m_idle = 0;
      model_clear();
    end else if (cmd_valid) begin
      m_idle = 0;
      case (cmd)
        3'd0: ;
        3'd1: m_state = (m_state + 1) % N;
        3'd2: m_state = (m_state + N - 1) % N;
        3'd3: m_state = 0;
        3'd4: if (int'(cmd_arg) < N) m_state = int'(cmd_arg); else bad = 1'b1;
        default: bad = 1'b1;
      endcase
      if (bad) begin
        m_sticky = 1'b1;
        if (err_clr) m_err = 1;
        else begin
          m_err = (m_err < ME) ? m_err + 1 : ME;
          if (m_err == ME) begin
            m_locked = 1'b1;
            m_state = 0;
          end
        end
      end else begin
        model_clear();
      end
    end else begin
      model_clear();
      if (m_state == 0) m_idle = 0;
      else begin
        m_idle++;
        if (TO != 0 && m_idle == TO) begin
          m_state = 0;
          m_idle = 0;
        end
      end
    end
  endtask

  task automatic drive(input bit v, input logic [2:0] c, input logic [SW-1:0] a, input bit clr);
    cmd_valid = v; cmd = c; cmd_arg = a; err_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply(input string tag, input bit v, input logic [2:0] c,
                       input logic [SW-1:0] a, input bit clr);
    drive(v, c, a, clr);
    tick();
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag);
    drive(1'b0, 3'd0, 3'd0, 1'b0);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 3'd0, 1'b0);
    model_reset();
    #3;

    // 1: wrap-around advance
    do_reset("t1.rst");
    for (int i = 1; i <= 6; i++) begin
      apply("t1", 1'b1, 3'd1, 3'd0, 1'b0);
      chk("t1.seq", 32'(state_out), 32'(i % 6));
      chk("t1.busy", 32'(busy), 32'(i % 6 != 0));
    end
    chk("t1.sticky", 32'(err_sticky), 32'd0);

    // 2: retreat wrap, legal and out-of-range jump
    apply("t2.ret", 1'b1, 3'd2, 3'd0, 1'b0);
    chk("t2.ret5", 32'(state_out), 32'd5);
    apply("t2.j3", 1'b1, 3'd4, 3'd3, 1'b0);
    chk("t2.j3v", 32'(state_out), 32'd3);
    apply("t2.j7", 1'b1, 3'd4, 3'd7, 1'b0);
    chk("t2.j7v", 32'(state_out), 32'd3);
    chk("t2.stk", 32'(err_sticky), 32'd1);
    chk("t2.cnt", 32'(dut.err_cnt_r), 32'd1);
    chk("t2.rdy", 32'(cmd_ready), 32'd1);

    // 3: lockout after three illegal opcodes
    do_reset("t3.rst");
    apply("t3.a", 1'b1, 3'd1, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) apply("t3.ill", 1'b1, 3'd5, 3'd0, 1'b0);
    chk("t3.lock", 32'(locked), 32'd1);
    chk("t3.rdy", 32'(cmd_ready), 32'd0);
    chk("t3.st0", 32'(state_out), 32'd0);
    apply("t3.adv", 1'b1, 3'd1, 3'd0, 1'b0);
    chk("t3.adv0", 32'(state_out), 32'd0);
    apply("t3.clr", 1'b0, 3'd0, 3'd0, 1'b1);
    chk("t3.clrlock", 32'(locked), 32'd1);
    do_reset("t3.rst2");
    chk("t3.unlock", 32'(locked), 32'd0);
    chk("t3.rdy1", 32'(cmd_ready), 32'd1);

    // 4: idle timeout, NOP restart, disabled timer
    do_reset("t4.rst");
    apply("t4.a1", 1'b1, 3'd1, 3'd0, 1'b0);
    apply("t4.a2", 1'b1, 3'd1, 3'd0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      apply("t4.idle", 1'b0, 3'd0, 3'd0, 1'b0);
      chk("t4.to", 32'(state_out), (i < 16) ? 32'd2 : 32'd0);
    end
    for (int i = 0; i < 20; i++) apply("t4.idle0", 1'b0, 3'd0, 3'd0, 1'b0);
    chk("t4.notimer", 32'(z_state), 32'd2);
    apply("t4.b1", 1'b1, 3'd1, 3'd0, 1'b0);
    apply("t4.b2", 1'b1, 3'd1, 3'd0, 1'b0);
    for (int i = 0; i < 14; i++) apply("t4.idle2", 1'b0, 3'd0, 3'd0, 1'b0);
    apply("t4.nop", 1'b1, 3'd0, 3'd0, 1'b0);
    apply("t4.c16", 1'b0, 3'd0, 3'd0, 1'b0);
    chk("t4.still2", 32'(state_out), 32'd2);
    for (int i = 2; i <= 16; i++) begin
      apply("t4.idle3", 1'b0, 3'd0, 3'd0, 1'b0);
      chk("t4.to2", 32'(state_out), (i < 16) ? 32'd2 : 32'd0);
    end

    // 5: out-of-range state recovery with a command pending
    do_reset("t5.rst");
    apply("t5.a", 1'b1, 3'd1, 3'd0, 1'b0);
    apply("t5.ill", 1'b1, 3'd6, 3'd0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 3'd1, 3'd0, 1'b0);
      if (k == 0) force dut.state_r = 3'd6;
      else        force dut.state_r = 3'd7;
      @(posedge clk);
      #1;
      release dut.state_r;
      drive(1'b0, 3'd0, 3'd0, 1'b0);
      chk("t5.fault", 32'(fault), 32'd1);
      chk("t5.cnt", 32'(dut.err_cnt_r), 32'd1);
      @(posedge clk);
      #1;
      chk("t5.st0", 32'(state_out), 32'd0);
      chk("t5.fault2", 32'(fault), 32'd1);
      chk("t5.cnt2", 32'(dut.err_cnt_r), 32'd1);
      chk("t5.lock", 32'(locked), 32'd0);
    end
    m_state = 0; m_idle = 0; m_fault = 1'b1;

    // 6: clear with the third illegal command, then async reset mid-stream
    do_reset("t6.rst");
    apply("t6.i1", 1'b1, 3'd6, 3'd0, 1'b0);
    apply("t6.i2", 1'b1, 3'd7, 3'd0, 1'b0);
    apply("t6.i3", 1'b1, 3'd5, 3'd0, 1'b1);
    chk("t6.cnt", 32'(dut.err_cnt_r), 32'd1);
    chk("t6.lock", 32'(locked), 32'd0);
    chk("t6.stk", 32'(err_sticky), 32'd1);
    apply("t6.a", 1'b1, 3'd1, 3'd0, 1'b0);
    drive(1'b1, 3'd1, 3'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6.st", 32'(state_out), 32'd0);
    chk("t6.busy", 32'(busy), 32'd0);
    chk("t6.stk0", 32'(err_sticky), 32'd0);
    chk("t6.cnt0", 32'(dut.err_cnt_r), 32'd0);
    chk("t6.rdy", 32'(cmd_ready), 32'd1);
    do_reset("t6.rst2");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [2:0] c;
      if (m_locked && $urandom_range(0, 5) == 0) do_reset("rnd.rst");
      if ($urandom_range(0, 40) == 0) begin
        for (int j = 0; j < 18; j++) apply("rnd.idle", 1'b0, 3'd0, 3'd0, 1'b0);
      end
      r = $urandom_range(0, 31);
      c = (r < 29) ? 3'(r % 5) : 3'(5 + (r % 3));
      apply("rnd", $urandom_range(0, 3) != 0, c, 3'($urandom_range(0, 7)),
            $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
